// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: transmit sequencer for the UART serializer.
// It accepts one character per valid/ready handshake, latches the frame
// shape, and paces the serializer's load/shift strobes at the baud rate
// until start, data, parity and stop bits have all left the line.
`timescale 1ns/1ps

module uart_tx_ctrl #(
  parameter int DSIZE = 8,
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DIV_W-1:0] baud_div,
  input  logic [3:0]       bit_width,
  input  logic             parity_en,
  input  logic             parity_odd,
  input  logic             stop2,
  input  logic [DSIZE-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic             sr_load,
  output logic             sr_shift,
  output logic             sr_parity,
  output logic [3:0]       sr_width,
  output logic             busy,
  output logic             done
);

  typedef enum logic {IDLE, SEND} state_e;

  state_e           state_q, state_d;
  logic [DIV_W-1:0] cnt_q,   cnt_d;    // clocks left in the current bit
  logic [3:0]       bits_q,  bits_d;   // shifts still owed for this frame
  logic [3:0]       width_q, width_d;  // data width captured at acceptance

  logic [3:0]       width_in;
  logic [DSIZE-1:0] data_masked;
  logic             par_even;
  logic [3:0]       n_bits;
  logic             accept;
  logic             shift_fire;
  logic             last_shift;

  // Normalize the live width, mask unused data bits, derive parity and frame length.
  always_comb begin
    // NOTE: every signal written in an always_comb gets a default first, so no path can infer a latch.
    width_in    = ((bit_width >= 4'd5) && (bit_width <= 4'd8)) ? bit_width : 4'd8;
    data_masked = '0;
    for (int i = 0; i < DSIZE; i++) begin
      data_masked[i] = tx_data[i] & (i < int'(width_in));
    end
    par_even = ^data_masked;
    // start + data + optional parity + one or two stop bits; worst case 12 fits in 4 bits
    n_bits   = 4'd1 + width_in + {3'd0, parity_en} + (stop2 ? 4'd2 : 4'd1);
  end

  assign accept     = (state_q == IDLE) && tx_valid;
  assign shift_fire = (state_q == SEND) && (cnt_q == '0);
  assign last_shift = shift_fire && (bits_q == 4'd1);

  // Next-state logic: accept a character in IDLE, pace the shifts in SEND.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bits_d  = bits_q;
    width_d = width_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SEND;
          cnt_d   = baud_div;
          bits_d  = n_bits;
          width_d = width_in;
        end
      end
      SEND: begin
        if (cnt_q == '0) begin
          // baud_div is re-sampled on every reload so a change affects only later bits
          cnt_d  = baud_div;
          bits_d = bits_q - 4'd1;
          if (bits_q == 4'd1) begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - DIV_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Controller state register with asynchronous reset back to an idle line.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bits_q  <= '0;
      width_q <= 4'd8;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bits_q  <= bits_d;
      width_q <= width_d;
    end
  end

  // Serializer controls; reset forces the safe values immediately, not just at the next edge.
  always_comb begin
    // NOTE: reset is used combinationally here so the outputs go to their idle values while reset is held.
    tx_ready  = (state_q == IDLE);
    busy      = (state_q == SEND);
    sr_load   = !reset && accept;
    sr_shift  = !reset && shift_fire;
    done      = !reset && last_shift;
    // with parity disabled the parity slot carries mark and acts as the first stop bit
    sr_parity = reset || !parity_en || (par_even ^ parity_odd);
    if (reset) begin
      sr_width = 4'd8;
    end else if (state_q == IDLE) begin
      sr_width = width_in;
    end else begin
      sr_width = width_q;
    end
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl with directed frames and a
// behavioural 10-bit serializer so the transmitted line can be checked.
`timescale 1ns/1ps

module tb_uart_tx_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] baud_div = '0;
  logic [3:0]  bit_width = 4'd8;
  logic        parity_en = 1'b0;
  logic        parity_odd = 1'b0;
  logic        stop2 = 1'b0;
  logic [7:0]  tx_data = '0;
  logic        tx_valid = 1'b0;
  logic        tx_ready, sr_load, sr_shift, sr_parity, busy, done;
  logic [3:0]  sr_width;

  int n_chk = 0;
  int n_bad = 0;
  int cyc   = 0;
  int viol  = 0;

  uart_tx_ctrl #(.DSIZE(8), .DIV_W(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .baud_div   (baud_div),
    .bit_width  (bit_width),
    .parity_en  (parity_en),
    .parity_odd (parity_odd),
    .stop2      (stop2),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .sr_load    (sr_load),
    .sr_shift   (sr_shift),
    .sr_parity  (sr_parity),
    .sr_width   (sr_width),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Serializer model: start bit in bit 0, data, parity slot, ones above; shifts in ones.
  logic [9:0] sr_q = '1;
  logic [9:0] sr_nx = '1;
  logic       line;
  assign line = sr_q[0];

  always @(negedge clk) begin
    sr_nx = sr_q;
    if (sr_load) begin
      sr_nx = '1;
      sr_nx[0] = 1'b0;
      for (int i = 0; i < int'(sr_width); i++) sr_nx[1+i] = tx_data[i];
      sr_nx[1+int'(sr_width)] = sr_parity;
    end else if (sr_shift) begin
      sr_nx = {1'b1, sr_q[9:1]};
    end
    if (!reset && sr_load && sr_shift) viol++;
    if (!reset && sr_load && busy) viol++;
  end

  always @(posedge clk or posedge reset) begin
    if (reset) sr_q <= '1;
    else       sr_q <= sr_nx;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Send one character and check strobes, timing and the line bits of the whole frame.
  task automatic run_frame(input string tag, input logic [7:0] data, input logic [3:0] bw,
                           input logic pen, input logic podd, input logic s2,
                           input logic [15:0] div, input int exp_n, input logic [3:0] exp_w,
                           input logic exp_par, input logic [11:0] exp_line, input bit chg);
    int dv, span, seq_err, n_sh, done_c;
    bit got_load;
    logic [11:0] line_got;
    dv = int'(div) + 1;
    span = exp_n * dv;
    seq_err = 0; n_sh = 0; done_c = -1; got_load = 0; line_got = '0;
    @(posedge clk); #1;
    tx_data = data; bit_width = bw; parity_en = pen; parity_odd = podd;
    stop2 = s2; baud_div = div; tx_valid = 1'b1;
    for (int i = 0; i < 10 && !got_load; i++) begin
      @(negedge clk);
      if (sr_load) got_load = 1;
    end
    check({tag, "_load"}, 32'(got_load), 1);
    if (!got_load) begin
      tx_valid = 1'b0;
      return;
    end
    check({tag, "_par"}, 32'(sr_parity), 32'(exp_par));
    check({tag, "_wload"}, 32'(sr_width), 32'(exp_w));
    @(posedge clk); #1;
    tx_valid = 1'b0;
    for (int c = 1; c <= span + 1; c++) begin
      @(negedge clk);
      if (chg && c == 3) begin
        bit_width = 4'd8; stop2 = 1'b1; parity_en = 1'b0;
      end
      if (sr_shift) n_sh++;
      if (done) done_c = c;
      if (sr_shift !== ((c % dv == 0) && c <= span)) seq_err++;
      if (busy !== (c <= span)) seq_err++;
      if (tx_ready !== !(c <= span)) seq_err++;
      if (sr_load) seq_err++;
      if (c <= span && sr_width !== exp_w) seq_err++;
      if ((c - 1) % dv == 0 && (c - 1) / dv < exp_n) line_got[(c - 1) / dv] = line;
      if (c == span + 1 && line !== 1'b1) seq_err++;
    end
    check({tag, "_nshift"}, n_sh, exp_n);
    check({tag, "_done_cyc"}, done_c, span);
    check({tag, "_seq"}, seq_err, 0);
    check({tag, "_line"}, 32'(line_got), 32'(exp_line));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int acc[3];
    int k, err, n_sh, a0;
    // Reset outputs, with live inputs that would otherwise change them.
    bit_width = 4'd5; parity_en = 1'b1; parity_odd = 1'b0; tx_data = 8'h00; tx_valid = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_ready",  32'(tx_ready),  1);
    check("rst_busy",   32'(busy),      0);
    check("rst_done",   32'(done),      0);
    check("rst_load",   32'(sr_load),   0);
    check("rst_shift",  32'(sr_shift),  0);
    check("rst_parity", 32'(sr_parity), 1);
    check("rst_width",  32'(sr_width),  8);
    check("rst_line",   32'(line),      1);
    tx_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;

    run_frame("f55",   8'h55, 4'd8,  1'b0, 1'b0, 1'b0, 16'd3, 10, 4'd8, 1'b1, 12'h2AA, 1'b0);
    run_frame("f93e",  8'h93, 4'd7,  1'b1, 1'b0, 1'b1, 16'd0, 11, 4'd7, 1'b1, 12'h726, 1'b0);
    run_frame("f93o",  8'h93, 4'd7,  1'b1, 1'b1, 1'b1, 16'd0, 11, 4'd7, 1'b0, 12'h626, 1'b0);
    run_frame("fbw12", 8'hA5, 4'd12, 1'b0, 1'b0, 1'b0, 16'd1, 10, 4'd8, 1'b1, 12'h34A, 1'b0);
    run_frame("fw5",   8'hEA, 4'd5,  1'b0, 1'b0, 1'b0, 16'd2,  7, 4'd5, 1'b1, 12'h054, 1'b0);
    run_frame("fchg",  8'h2D, 4'd6,  1'b1, 1'b0, 1'b0, 16'd1,  9, 4'd6, 1'b0, 12'h15A, 1'b1);
    run_frame("fnew",  8'h0F, 4'd8,  1'b0, 1'b0, 1'b1, 16'd0, 11, 4'd8, 1'b1, 12'h61E, 1'b0);

    // Back-to-back: tx_valid held high for three characters.
    @(posedge clk); #1;
    baud_div = 16'd1; bit_width = 4'd8; parity_en = 1'b0; stop2 = 1'b0;
    tx_data = 8'h3C; tx_valid = 1'b1;
    k = 0; err = 0;
    for (int i = 0; i < 100 && k < 3; i++) begin
      @(negedge clk);
      if (tx_ready === busy) err++;
      if (sr_load) begin
        acc[k] = cyc;
        k++;
        if (line !== 1'b1) err++;
      end
    end
    @(posedge clk); #1;
    tx_valid = 1'b0;
    repeat (25) begin
      @(negedge clk);
      if (tx_ready === busy) err++;
      if (sr_load) err++;
    end
    check("b2b_count", k, 3);
    if (k == 3) begin
      check("b2b_gap1", acc[1] - acc[0], 21);
      check("b2b_gap2", acc[2] - acc[1], 21);
    end
    check("b2b_err", err, 0);

    // Reset asserted in the middle of bit 4 of a frame.
    @(posedge clk); #1;
    baud_div = 16'd3; tx_data = 8'h55; tx_valid = 1'b1;
    a0 = 0;
    for (int i = 0; i < 10 && a0 == 0; i++) begin
      @(negedge clk);
      if (sr_load) a0 = 1;
    end
    check("mrst_load", a0, 1);
    @(posedge clk); #1;
    tx_valid = 1'b0;
    repeat (17) @(negedge clk);
    check("mrst_pre_busy", 32'(busy), 1);
    #2 reset = 1'b1;
    #1;
    check("mrst_now_busy",  32'(busy),     0);
    check("mrst_now_ready", 32'(tx_ready), 1);
    check("mrst_now_line",  32'(line),     1);
    check("mrst_now_width", 32'(sr_width), 8);
    @(negedge clk);
    check("mrst_next_busy",  32'(busy),     0);
    check("mrst_next_ready", 32'(tx_ready), 1);
    check("mrst_next_line",  32'(line),     1);
    @(posedge clk); #1;
    reset = 1'b0;
    n_sh = 0;
    repeat (20) begin
      @(negedge clk);
      if (sr_shift) n_sh++;
    end
    check("mrst_no_shift", n_sh, 0);
    check("mrst_idle_line", 32'(line), 1);

    check("strobe_overlap", viol, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
